cl_head_gen: RTL and testbench
==============================

Name: cl_head_gen

Overview:
- Transmit-side counterpart of the cache-line header analyser.
- Packs an incoming stream of symbols (STs) belonging to one AFU frame into 512-bit cache lines (CLs), each carrying a 16-bit header and a 496-bit payload.
- Header per CL: ST count for that CL and an end-of-frame flag. The frame's total ST count is reported on a sideband.
- Sits between the ST producer and the CL fifo/link feeding the analyser.

Parameters:
- CL, 512, cache-line width in bits
- CL_HEAD, 16, header width in bits
- CL_PAYLOAD, 496, payload width in bits (CL - CL_HEAD)
- W_ST, 8, width of one ST in bits
- w_NumOfST_in_AFUFrm, 16, width of the frame-length ST counter
- Derived, not overridable: ST_PER_CL = CL_PAYLOAD / W_ST = 62. ST_PER_CL must be ≤ 1023 to fit the 10-bit count field.

Ports:
- clk, input, 1, clock; all logic on the rising edge
- rst, input, 1, reset, asynchronous, active-high
- sink_data, input, W_ST, one ST
- sink_valid, input, 1, ST valid
- sink_last, input, 1, this ST is the last of the AFU frame
- sink_ready, output, 1, block accepts an ST this cycle
- source_data, output, CL, assembled cache line
- source_valid, output, 1, CL valid
- source_ready, input, 1, downstream accepts the CL
- sb_len, output, w_NumOfST_in_AFUFrm, total STs in the last completed frame
- sb_len_valid, output, 1, one-cycle pulse when sb_len updates

Behaviour:
- Reset values: source_data = 0, source_valid = 0, sb_len = 0, sb_len_valid = 0. Internal state: FSM = S_FILL, slot counter = 0, frame counter = 0, payload buffer = 0.
- Reset asserted mid-frame: the partial CL and the frame count are discarded. No CL is emitted for them.
- ST accept: a cycle with sink_valid & sink_ready. sink_ready = (fsm == S_FILL), combinational from the state register.
- CL layout:
  - bits [CL-1:CL-5] = 0 (reserved)
  - bit [CL-6] = EOF flag
  - bits [CL-7:CL-16] = number of valid STs in this CL (1..ST_PER_CL)
  - payload bits [CL_PAYLOAD-1:0]: ST k of the CL (k = 0 first accepted) at bits [k*W_ST +: W_ST]
  - unused slots are 0
- FSM states:
  - S_FILL: each accepted ST is written to slot cnt, then cnt++. When the accepted ST has cnt == ST_PER_CL-1 or sink_last = 1, the next cycle presents the CL on source_data with source_valid = 1, EOF = sink_last, count = cnt+1, and the FSM goes to S_OUT.
  - S_OUT: sink_ready = 0. Hold source_data and source_valid stable until source_ready = 1. On handshake: source_valid drops next cycle, buffer and cnt clear, FSM returns to S_FILL.
- Latency: CL valid 1 cycle after its final ST is accepted.
- Throughput: ST_PER_CL+1 cycles minimum per full CL (one bubble cycle per CL).
- Simultaneous full and last (62nd ST with sink_last = 1): a single CL with count = 62 and EOF = 1. No empty trailing CL is ever emitted.
- Frame counter: incremented on every accepted ST; arithmetic is modulo 2^w_NumOfST_in_AFUFrm (wraps silently).
- On the handshake of an EOF CL:
  - sb_len <= frame count including the final ST
  - sb_len_valid = 1 for exactly one cycle
  - frame counter clears
- sb_len holds its value until the next EOF handshake.
- The sum of the count fields over a frame's CLs equals sb_len (mod 2^w).
- sink_valid low while in S_FILL: state is held and no CL is emitted. No timeout flush exists; a partial CL leaves only on sink_last or on a full CL.
- source_ready asserted while source_valid = 0: ignored.

Test Plan:
1. Frame of 5 STs 0x01..0x05, last on the 5th, source_ready = 1 → one CL: bit506 = 1, bits[505:496] = 5, payload[39:0] = 0x0504030201, rest 0. sb_len = 5 with sb_len_valid pulsing once.
2. Frame of 130 STs → three CLs with counts 62/62/6 and EOF 0/0/1. sb_len = 130. The sink stalls exactly one cycle after each CL is presented.
3. Frame of exactly 62 STs, last on the 62nd → one CL, count = 62, EOF = 1. No second CL. sb_len = 62.
4. source_ready held low for 10 cycles after a CL is presented → source_data/source_valid stable, sink_ready = 0 throughout. Handshake on cycle 11, then accept resumes on the next cycle.
5. Async rst pulse after 30 STs of a frame → outputs zero immediately. A following 3-ST frame yields one CL with count = 3, EOF = 1 and sb_len = 3, with no residue from the aborted frame.
6. Frame of 65 537 STs with w = 16 → sb_len = 1 (wrap); every CL count field is still correct.

Source files
------------

// File: rtl/cl_head_gen_if.sv
// Stream-side bundle for cl_head_gen: the ST sink and the cache-line source.
// master = the packer's view, slave = the producer/consumer side.
interface cl_head_gen_if #(
   parameter int CL   = 512,
   parameter int W_ST = 8
);
   logic [W_ST-1:0] sink_data;
   logic            sink_valid;
   logic            sink_last;
   logic            sink_ready;
   logic [CL-1:0]   source_data;
   logic            source_valid;
   logic            source_ready;

   modport master (
      input  sink_data, sink_valid, sink_last, source_ready,
      output sink_ready, source_data, source_valid
   );

   modport slave (
      output sink_data, sink_valid, sink_last, source_ready,
      input  sink_ready, source_data, source_valid
   );
endinterface

// File: rtl/cl_head_gen.sv
// Packs a stream of STs belonging to one AFU frame into cache lines with a
// 16-bit header {reserved, eof, st_count} and a 496-bit payload; reports the
// frame's total ST count on a sideband when its final cache line leaves.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holding valid keeps its data stable until that edge,
// and ready may depend combinationally on state but never on valid.
module cl_head_gen #(
   parameter int CL                  = 512,
   parameter int CL_HEAD             = 16,
   parameter int CL_PAYLOAD          = 496,
   parameter int W_ST                = 8,
   parameter int w_NumOfST_in_AFUFrm = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   cl_head_gen_if.master                  bus,
   output logic [w_NumOfST_in_AFUFrm-1:0] sb_len,
   output logic                           sb_len_valid,
   output logic [0:0]                     dbg_state
);
   localparam int ST_PER_CL = CL_PAYLOAD / W_ST;
   localparam int W_RSV     = CL_HEAD - 11;
   localparam logic [9:0] LAST_SLOT = 10'(ST_PER_CL - 1);

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_OUT  = 1'b1;

   logic [0:0]                     state_q, state_d;
   logic [9:0]                     cnt_q, cnt_d;
   logic [w_NumOfST_in_AFUFrm-1:0] frm_q, frm_d;
   logic [CL_PAYLOAD-1:0]          buf_q, buf_d;
   logic [CL-1:0]                  src_data_q, src_data_d;
   logic                           src_valid_q, src_valid_d;
   logic [w_NumOfST_in_AFUFrm-1:0] sb_len_q, sb_len_d;
   logic                           sb_len_valid_q, sb_len_valid_d;

   // Next-state: fill slots in S_FILL, close the line on full or last, then
   // hold it in S_OUT until the consumer takes it.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      frm_d          = frm_q;
      buf_d          = buf_q;
      src_data_d     = src_data_q;
      src_valid_d    = src_valid_q;
      sb_len_d       = sb_len_q;
      sb_len_valid_d = 1'b0;
      case (state_q)
         S_FILL: begin
            if (bus.sink_valid) begin
               buf_d[cnt_q*W_ST +: W_ST] = bus.sink_data;
               cnt_d = cnt_q + 10'd1;
               frm_d = frm_q + 1'b1;
               // A full line that is also the last ST closes as one EOF line,
               // so no empty trailing line can ever appear.
               if ((cnt_q == LAST_SLOT) || bus.sink_last) begin
                  src_data_d  = {{W_RSV{1'b0}}, bus.sink_last, cnt_q + 10'd1, buf_d};
                  src_valid_d = 1'b1;
                  state_d     = S_OUT;
               end
            end
         end
         default: begin
            if (bus.source_ready) begin
               src_valid_d = 1'b0;
               buf_d       = '0;
               cnt_d       = '0;
               state_d     = S_FILL;
               // The frame count already includes the final ST, accepted earlier.
               if (src_data_q[CL-6]) begin
                  sb_len_d       = frm_q;
                  sb_len_valid_d = 1'b1;
                  frm_d          = '0;
               end
            end
         end
      endcase
   end

   // State registers; reset drops any partial line and frame count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_FILL;
         cnt_q          <= '0;
         frm_q          <= '0;
         buf_q          <= '0;
         src_data_q     <= '0;
         src_valid_q    <= 1'b0;
         sb_len_q       <= '0;
         sb_len_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         frm_q          <= frm_d;
         buf_q          <= buf_d;
         src_data_q     <= src_data_d;
         src_valid_q    <= src_valid_d;
         sb_len_q       <= sb_len_d;
         sb_len_valid_q <= sb_len_valid_d;
      end
   end

   assign bus.sink_ready   = (state_q == S_FILL);
   assign bus.source_data  = src_data_q;
   assign bus.source_valid = src_valid_q;
   assign sb_len           = sb_len_q;
   assign sb_len_valid     = sb_len_valid_q;
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_cl_head_gen.sv
// Directed bench for cl_head_gen: frames of several lengths, back-pressure,
// mid-frame reset and frame-counter wrap.
module tb_cl_head_gen;
   logic        clk;
   logic        rst;
   logic [15:0] sb_len;
   logic        sb_len_valid;
   logic [0:0]  dbg_state;

   cl_head_gen_if #(.CL(512), .W_ST(8)) bus ();

   cl_head_gen dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .sb_len       (sb_len),
      .sb_len_valid (sb_len_valid),
      .dbg_state    (dbg_state)
   );

   int checks    = 0;
   int errors    = 0;
   int sb_pulses = 0;
   logic [511:0] exp_q[$];
   logic [15:0]  sb_q[$];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mk_cl(input int first, input int cnt, input bit eof, input int seed);
      logic [511:0] c;
      c = '0;
      c[506] = eof;
      c[505:496] = 10'(cnt);
      for (int k = 0; k < cnt; k++) c[k*8 +: 8] = 8'(seed + first + k);
      return c;
   endfunction

   // scoreboard: every accepted cache line and every sideband pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.source_valid && bus.source_ready) begin
            if (exp_q.size() == 0) check("cl_unexpected", 512'(exp_q.size()), 512'd1);
            else check("cl", bus.source_data, exp_q.pop_front());
         end
         if (sb_len_valid) begin
            sb_pulses++;
            if (sb_q.size() == 0) check("sb_unexpected", 512'(sb_q.size()), 512'd1);
            else check("sb_len", 512'(sb_len), 512'(sb_q.pop_front()));
         end
      end
   end

   // driver: n STs of value seed+i; optionally queue the expected lines
   task automatic send_frame(input int n, input int seed, input bit push,
                             input bit last_flag, output int stalls);
      int cnt;
      stalls = 0;
      if (push) begin
         for (int first = 0; first < n; first += 62) begin
            cnt = (n - first > 62) ? 62 : n - first;
            exp_q.push_back(mk_cl(first, cnt, (first + cnt == n) && last_flag, seed));
         end
         if (last_flag) sb_q.push_back(16'(n));
      end
      for (int i = 0; i < n; i++) begin
         int wait_cyc;
         bus.sink_valid = 1'b1;
         bus.sink_data  = 8'(seed + i);
         bus.sink_last  = last_flag && (i == n - 1);
         wait_cyc = 0;
         forever begin
            @(negedge clk);
            if (bus.sink_ready) break;
            if (i > 0) stalls++;
            wait_cyc++;
            if (wait_cyc > 100) break;
         end
         if (wait_cyc > 100) begin
            check("sink_ready_timeout", 512'd0, 512'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      bus.sink_valid = 1'b0;
      bus.sink_last  = 1'b0;
      bus.sink_data  = '0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      check(tag, 512'(exp_q.size()), 512'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int stalls;
      logic [511:0] hold_cl;
      bus.sink_valid   = 1'b0;
      bus.sink_last    = 1'b0;
      bus.sink_data    = '0;
      bus.source_ready = 1'b1;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_source_data", bus.source_data, 512'd0);
      check("rst_source_valid", 512'(bus.source_valid), 512'd0);
      check("rst_sb_len", 512'(sb_len), 512'd0);
      check("rst_sb_len_valid", 512'(sb_len_valid), 512'd0);
      check("rst_sink_ready", 512'(bus.sink_ready), 512'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: five STs, hand-computed line
      exp_q.push_back({5'b0, 1'b1, 10'd5, 456'd0, 40'h0504030201});
      sb_q.push_back(16'd5);
      send_frame(5, 1, 1'b0, 1'b1, stalls);
      check("t1_stalls", 512'(stalls), 512'd0);
      drain("t1_drain");
      check("t1_sb_len_hold", 512'(sb_len), 512'd5);
      check("t1_sb_pulse_low", 512'(sb_len_valid), 512'd0);

      // 2: 130 STs -> 62/62/6, one bubble per presented line
      send_frame(130, 8'h10, 1'b1, 1'b1, stalls);
      check("t2_stalls", 512'(stalls), 512'd2);
      drain("t2_drain");

      // 3: exactly one full EOF line
      send_frame(62, 8'h80, 1'b1, 1'b1, stalls);
      drain("t3_drain");
      check("t3_sb_len", 512'(sb_len), 512'd62);

      // 4: consumer back-pressure for 10 cycles
      bus.source_ready = 1'b0;
      send_frame(3, 8'h40, 1'b1, 1'b1, stalls);
      hold_cl = exp_q[0];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t4_hold_data", bus.source_data, hold_cl);
         check("t4_hold_valid", 512'(bus.source_valid), 512'd1);
         check("t4_sink_ready_low", 512'(bus.sink_ready), 512'd0);
      end
      @(posedge clk);
      #1 bus.source_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t4_resume_ready", 512'(bus.sink_ready), 512'd1);
      check("t4_valid_dropped", 512'(bus.source_valid), 512'd0);
      drain("t4_drain");

      // 5: reset in the middle of a frame, then a clean 3-ST frame
      send_frame(30, 8'hA0, 1'b0, 1'b0, stalls);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", 512'(bus.source_valid), 512'd0);
      check("t5_rst_data", bus.source_data, 512'd0);
      check("t5_rst_sb_len", 512'(sb_len), 512'd0);
      check("t5_rst_ready", 512'(bus.sink_ready), 512'd1);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back({5'b0, 1'b1, 10'd3, 472'd0, 24'h030201});
      sb_q.push_back(16'd3);
      send_frame(3, 1, 1'b0, 1'b1, stalls);
      drain("t5_drain");
      check("t5_sb_len", 512'(sb_len), 512'd3);

      // 6: 65537 STs -> 1057 full lines + one of 3, length wraps to 1
      send_frame(65537, 8'h05, 1'b1, 1'b1, stalls);
      drain("t6_drain");
      check("t6_sb_len_wrap", 512'(sb_len), 512'd1);

      check("sb_queue_empty", 512'(sb_q.size()), 512'd0);
      check("sb_pulse_count", 512'(sb_pulses), 512'd6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
